// File: rtl/fixed_point_pkg.sv
// Signed fixed-point sample type shared by the perceptron datapath and its monitors.
// Q8.8 format: +1.0 is 16'sh0100.
package FixedPoint;
  typedef logic signed [15:0] sfp;
  localparam sfp SFP_ZERO = '0;
endpackage

// File: rtl/perceptron_train_monitor_if.sv
// Sample stream and training-status bundle between a perceptron and its training monitor.
interface perceptron_train_monitor_if;
  logic            start;
  logic            sample_valid;
  FixedPoint::sfp  prediction;
  FixedPoint::sfp  expected;
  logic            training;
  logic [15:0]     epoch;
  logic [7:0]      epoch_errors;
  logic [15:0]     total_errors;
  logic            converged;
  logic            timeout;
  logic            done;

  modport master (
    output start, sample_valid, prediction, expected,
    input  training, epoch, epoch_errors, total_errors, converged, timeout, done
  );

  modport slave (
    input  start, sample_valid, prediction, expected,
    output training, epoch, epoch_errors, total_errors, converged, timeout, done
  );
endinterface

// File: rtl/perceptron_train_monitor.sv
// Counts perceptron misclassifications per epoch and ends a training run on
// convergence (enough clean epochs in a row) or on reaching the epoch limit.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no run since reset; waiting for start
//   RUN       | training enabled; accepting labelled samples
//   CONVERGED | run ended after CLEAN_EPOCHS consecutive error-free epochs
//   TIMEOUT   | run ended after MAX_EPOCHS epochs without converging
module perceptron_train_monitor #(
  parameter int SAMPLES_PER_EPOCH = 4,
  parameter int MAX_EPOCHS        = 10,
  parameter int CLEAN_EPOCHS      = 2
) (
  input logic                        clk,
  input logic                        rst,
  perceptron_train_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    CONVERGED = 2'd2,
    TIMEOUT   = 2'd3
  } state_t;

  localparam logic [7:0]  LAST_IDX  = 8'(SAMPLES_PER_EPOCH - 1);
  localparam logic [15:0] MAX_EP    = 16'(MAX_EPOCHS);
  localparam logic [15:0] CLEAN_REQ = 16'(CLEAN_EPOCHS);

  state_t      state_q, state_n;
  logic [7:0]  sample_idx_q, sample_idx_n;
  logic [7:0]  run_errors_q, run_errors_n;
  logic [15:0] clean_cnt_q, clean_cnt_n;
  logic [15:0] epoch_q, epoch_n;
  logic [7:0]  epoch_errors_q, epoch_errors_n;
  logic [15:0] total_errors_q, total_errors_n;
  logic        converged_q, converged_n;
  logic        timeout_q, timeout_n;
  logic        done_q, done_n;
  logic        training_q, training_n;

  logic        pred_class;
  logic        exp_class;
  logic        mismatch;
  logic [7:0]  run_errors_upd;
  logic [15:0] epoch_upd;
  logic [15:0] clean_upd;

  assign pred_class = (mon.prediction > FixedPoint::SFP_ZERO);
  assign exp_class  = (mon.expected   > FixedPoint::SFP_ZERO);
  assign mismatch   = pred_class ^ exp_class;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      sample_idx_q   <= '0;
      run_errors_q   <= '0;
      clean_cnt_q    <= '0;
      epoch_q        <= '0;
      epoch_errors_q <= '0;
      total_errors_q <= '0;
      converged_q    <= 1'b0;
      timeout_q      <= 1'b0;
      done_q         <= 1'b0;
      training_q     <= 1'b0;
    end else begin
      state_q        <= state_n;
      sample_idx_q   <= sample_idx_n;
      run_errors_q   <= run_errors_n;
      clean_cnt_q    <= clean_cnt_n;
      epoch_q        <= epoch_n;
      epoch_errors_q <= epoch_errors_n;
      total_errors_q <= total_errors_n;
      converged_q    <= converged_n;
      timeout_q      <= timeout_n;
      done_q         <= done_n;
      training_q     <= training_n;
    end
  end

  always_comb begin
    state_n        = state_q;
    sample_idx_n   = sample_idx_q;
    run_errors_n   = run_errors_q;
    clean_cnt_n    = clean_cnt_q;
    epoch_n        = epoch_q;
    epoch_errors_n = epoch_errors_q;
    total_errors_n = total_errors_q;
    converged_n    = converged_q;
    timeout_n      = timeout_q;
    done_n         = 1'b0;
    run_errors_upd = run_errors_q;
    epoch_upd      = epoch_q + 16'd1;
    clean_upd      = clean_cnt_q;

    if (mismatch && (run_errors_q != 8'hFF)) begin
      run_errors_upd = run_errors_q + 8'd1;
    end

    case (state_q)
      RUN: begin
        if (mon.sample_valid) begin
          if (mismatch && (total_errors_q != 16'hFFFF)) begin
            total_errors_n = total_errors_q + 16'd1;
          end
          if (sample_idx_q == LAST_IDX) begin
            clean_upd      = (run_errors_upd == 8'd0) ? clean_cnt_q + 16'd1 : 16'd0;
            epoch_n        = epoch_upd;
            epoch_errors_n = run_errors_upd;
            clean_cnt_n    = clean_upd;
            run_errors_n   = '0;
            sample_idx_n   = '0;
            // Convergence wins when the last allowed epoch is also the clean one.
            if (clean_upd == CLEAN_REQ) begin
              state_n     = CONVERGED;
              converged_n = 1'b1;
              done_n      = 1'b1;
            end else if (epoch_upd == MAX_EP) begin
              state_n   = TIMEOUT;
              timeout_n = 1'b1;
              done_n    = 1'b1;
            end
          end else begin
            sample_idx_n = sample_idx_q + 8'd1;
            run_errors_n = run_errors_upd;
          end
        end
      end
      default: begin
        if (mon.start) begin
          state_n        = RUN;
          sample_idx_n   = '0;
          run_errors_n   = '0;
          clean_cnt_n    = '0;
          epoch_n        = '0;
          epoch_errors_n = '0;
          total_errors_n = '0;
          converged_n    = 1'b0;
          timeout_n      = 1'b0;
        end
      end
    endcase

    training_n = (state_n == RUN);
  end

  assign mon.training     = training_q;
  assign mon.epoch        = epoch_q;
  assign mon.epoch_errors = epoch_errors_q;
  assign mon.total_errors = total_errors_q;
  assign mon.converged    = converged_q;
  assign mon.timeout      = timeout_q;
  assign mon.done         = done_q;

endmodule

// File: tb/tb_perceptron_train_monitor.sv
// Directed bench for perceptron_train_monitor: scoreboard fed by a reference model,
// plus spot checks of the headline scenarios on a default and a short-limit instance.
module tb_perceptron_train_monitor;

  localparam int SPE   = 4;
  localparam int MAXE  = 10;
  localparam int CLEAN = 2;

  localparam FixedPoint::sfp P1 = 16'sh0100;
  localparam FixedPoint::sfp N1 = 16'shFF00;
  localparam FixedPoint::sfp Z  = 16'sh0000;
  localparam FixedPoint::sfp T1 = 16'sh0001;

  typedef struct {
    logic        tr;
    logic [15:0] ep;
    logic [7:0]  ee;
    logic [15:0] te;
    logic        cv;
    logic        to;
    logic        dn;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  int m_state, m_idx, m_run, m_clean, m_epoch, m_eerr, m_tot;
  bit m_conv, m_tmo, m_done, m_train;

  perceptron_train_monitor_if if_a ();
  perceptron_train_monitor_if if_b ();

  assign if_b.start        = if_a.start;
  assign if_b.sample_valid = if_a.sample_valid;
  assign if_b.prediction   = if_a.prediction;
  assign if_b.expected     = if_a.expected;

  perceptron_train_monitor dut_a (.clk(clk), .rst(rst), .mon(if_a));

  perceptron_train_monitor #(
    .SAMPLES_PER_EPOCH(4), .MAX_EPOCHS(2), .CLEAN_EPOCHS(2)
  ) dut_b (.clk(clk), .rst(rst), .mon(if_b));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model(input bit r, input bit s, input bit v,
                       input FixedPoint::sfp p, input FixedPoint::sfp e);
    bit mis;
    if (r) begin
      m_state = 0; m_idx = 0; m_run = 0; m_clean = 0; m_epoch = 0;
      m_eerr = 0; m_tot = 0; m_conv = 0; m_tmo = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_state != 1) begin
        if (s) begin
          m_state = 1; m_idx = 0; m_run = 0; m_clean = 0; m_epoch = 0;
          m_eerr = 0; m_tot = 0; m_conv = 0; m_tmo = 0;
        end
      end else if (v) begin
        mis = ((p > 0) != (e > 0));
        if (mis) begin
          if (m_run < 255) m_run++;
          if (m_tot < 65535) m_tot++;
        end
        if (m_idx == SPE - 1) begin
          m_epoch++;
          m_eerr  = m_run;
          m_clean = (m_run == 0) ? m_clean + 1 : 0;
          m_run   = 0;
          m_idx   = 0;
          if (m_clean == CLEAN) begin
            m_state = 2; m_conv = 1; m_done = 1;
          end else if (m_epoch == MAXE) begin
            m_state = 3; m_tmo = 1; m_done = 1;
          end
        end else begin
          m_idx++;
        end
      end
    end
    m_train = (m_state == 1);
  endtask

  task automatic step(input bit r, input bit s, input bit v,
                      input FixedPoint::sfp p, input FixedPoint::sfp e, input string tag);
    exp_t nx;
    exp_t cur;
    rst               = r;
    if_a.start        = s;
    if_a.sample_valid = v;
    if_a.prediction   = p;
    if_a.expected     = e;
    model(r, s, v, p, e);
    nx.tr = m_train; nx.ep = 16'(m_epoch); nx.ee = 8'(m_eerr); nx.te = 16'(m_tot);
    nx.cv = m_conv;  nx.to = m_tmo;        nx.dn = m_done;
    sb.push_back(nx);
    @(posedge clk);
    #1;
    cur = sb.pop_front();
    chk({tag, ".training"},     32'(if_a.training),     32'(cur.tr));
    chk({tag, ".epoch"},        32'(if_a.epoch),        32'(cur.ep));
    chk({tag, ".epoch_errors"}, 32'(if_a.epoch_errors), 32'(cur.ee));
    chk({tag, ".total_errors"}, 32'(if_a.total_errors), 32'(cur.te));
    chk({tag, ".converged"},    32'(if_a.converged),    32'(cur.cv));
    chk({tag, ".timeout"},      32'(if_a.timeout),      32'(cur.to));
    chk({tag, ".done"},         32'(if_a.done),         32'(cur.dn));
  endtask

  task automatic smp(input FixedPoint::sfp p, input FixedPoint::sfp e, input string tag);
    step(1'b0, 1'b0, 1'b1, p, e, tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 1'b0, Z, Z, tag);
  endtask

  initial begin
    // reset state
    step(1'b1, 1'b0, 1'b0, Z, Z, "rst0");
    step(1'b1, 1'b1, 1'b1, P1, Z, "rst1");
    chk("rst.training", 32'(if_a.training), 32'd0);
    chk("rst.epoch",    32'(if_a.epoch),    32'd0);
    idle("idle0");

    // 8 matching samples -> convergence after epoch 2
    step(1'b0, 1'b1, 1'b1, P1, Z, "start_a");
    chk("start_a.training", 32'(if_a.training), 32'd1);
    chk("start_a.total",    32'(if_a.total_errors), 32'd0);
    for (int i = 0; i < 8; i++) smp(P1, P1, "conv8");
    chk("conv8.converged", 32'(if_a.converged),    32'd1);
    chk("conv8.done",      32'(if_a.done),         32'd1);
    chk("conv8.epoch",     32'(if_a.epoch),        32'd2);
    chk("conv8.total",     32'(if_a.total_errors), 32'd0);
    chk("conv8.training",  32'(if_a.training),     32'd0);
    chk("prio.converged",  32'(if_b.converged),    32'd1);
    chk("prio.timeout",    32'(if_b.timeout),      32'd0);
    chk("prio.epoch",      32'(if_b.epoch),        32'd2);
    idle("conv_hold");
    chk("conv_hold.done",  32'(if_a.done),         32'd0);

    // samples in CONVERGED are ignored, then start restarts
    smp(P1, Z, "conv_ign0");
    smp(N1, P1, "conv_ign1");
    chk("conv_ign.epoch", 32'(if_a.epoch), 32'd2);
    chk("conv_ign.total", 32'(if_a.total_errors), 32'd0);
    step(1'b0, 1'b1, 1'b0, Z, Z, "restart_c");
    chk("restart_c.training", 32'(if_a.training),  32'd1);
    chk("restart_c.epoch",    32'(if_a.epoch),     32'd0);
    chk("restart_c.conv",     32'(if_a.converged), 32'd0);

    // one mismatch per epoch with gaps -> timeout at epoch 10
    for (int ep = 0; ep < 10; ep++) begin
      smp(P1, Z, "tmo_mis");
      if (ep % 3 == 0) idle("tmo_gap");
      for (int k = 1; k < 4; k++) smp(P1, P1, "tmo_ok");
    end
    chk("tmo.timeout",   32'(if_a.timeout),      32'd1);
    chk("tmo.converged", 32'(if_a.converged),    32'd0);
    chk("tmo.epoch",     32'(if_a.epoch),        32'd10);
    chk("tmo.eerr",      32'(if_a.epoch_errors), 32'd1);
    chk("tmo.total",     32'(if_a.total_errors), 32'd10);
    chk("tmo.done",      32'(if_a.done),         32'd1);
    idle("tmo_hold");

    // epoch errors 1,0,1,0,0 -> converge after epoch 5; zero vs zero is a match
    step(1'b0, 1'b1, 1'b0, Z, Z, "start_e");
    for (int ep = 0; ep < 5; ep++) begin
      if (ep == 0 || ep == 2) smp(N1, P1, "cl_mis");
      else smp(Z, Z, "cl_zero");
      smp(T1, P1, "cl_tiny");
      smp(Z, N1, "cl_neg");
      step(1'b0, 1'b1, 1'b1, Z, Z, "cl_start_ign");
      if (ep == 3) begin
        chk("cl4.converged", 32'(if_a.converged), 32'd0);
        chk("cl4.epoch",     32'(if_a.epoch),     32'd4);
      end
    end
    chk("cl5.converged", 32'(if_a.converged),    32'd1);
    chk("cl5.epoch",     32'(if_a.epoch),        32'd5);
    chk("cl5.total",     32'(if_a.total_errors), 32'd2);
    chk("cl5.eerr",      32'(if_a.epoch_errors), 32'd0);

    // reset mid-run discards the partial epoch
    step(1'b0, 1'b1, 1'b0, Z, Z, "start_r");
    smp(P1, Z, "mid0");
    smp(P1, P1, "mid1");
    smp(P1, Z, "mid2");
    step(1'b1, 1'b0, 1'b1, P1, Z, "mid_rst");
    chk("mid_rst.total",    32'(if_a.total_errors), 32'd0);
    chk("mid_rst.training", 32'(if_a.training),     32'd0);
    smp(P1, Z, "nostart0");
    smp(P1, Z, "nostart1");
    chk("nostart.total", 32'(if_a.total_errors), 32'd0);
    step(1'b0, 1'b1, 1'b1, P1, Z, "start_s");
    for (int i = 0; i < 4; i++) smp((i == 1) ? P1 : Z, Z, "post_rst");
    chk("post_rst.epoch", 32'(if_a.epoch),        32'd1);
    chk("post_rst.eerr",  32'(if_a.epoch_errors), 32'd1);
    chk("post_rst.total", 32'(if_a.total_errors), 32'd1);
    idle("end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/perceptron_train_monitor.md
PERCEPTRON_TRAIN_MONITOR -- requirements
Module: perceptron_train_monitor

Interface
REQ-001 SHALL have parameter SAMPLES_PER_EPOCH, default 4, number of labelled samples per training epoch (range 1..255).
REQ-002 SHALL have parameter MAX_EPOCHS, default 10, epoch limit before timeout (range 1..65535).
REQ-003 SHALL have parameter CLEAN_EPOCHS, default 2, consecutive error-free epochs required for convergence (range 1..MAX_EPOCHS).
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  single-cycle request to begin a monitoring run.
REQ-007 sample_valid  in  1  prediction/expected pair is valid this cycle.
REQ-008 prediction  in  FixedPoint::sfp  perceptron output for the current sample.
REQ-009 expected  in  FixedPoint::sfp  label for the current sample.
REQ-010 training  out  1  high while in RUN; drives the perceptron training enable.
REQ-011 epoch  out  16  completed epochs in the current run.
REQ-012 epoch_errors  out  8  misclassification count of the last completed epoch.
REQ-013 total_errors  out  16  misclassifications in the current run, saturating at 16'hFFFF.
REQ-014 converged  out  1  sticky; run ended by convergence.
REQ-015 timeout  out  1  sticky; run ended by reaching MAX_EPOCHS.
REQ-016 done  out  1  one-cycle pulse when a run ends.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, CONVERGED, TIMEOUT; all outputs registered.
REQ-018 IDLE/CONVERGED/TIMEOUT: start=1 -> RUN next cycle; clears epoch, epoch_errors, total_errors, sample index, clean-epoch count, converged, timeout.
REQ-019 RUN: start ignored; training=1 in every RUN cycle, 0 in all other states.
REQ-020 sample_valid SHALL be accepted only in RUN; ignored in other states, including the cycle start is sampled.
REQ-021 Classification: predicted class = (prediction > 0), expected class = (expected > 0), signed compare; mismatch = one error.
REQ-022 Each accepted sample increments the sample index (0..SAMPLES_PER_EPOCH-1) and, on mismatch, the running epoch error count (saturating at 255) and total_errors (saturating).
REQ-023 Accepted sample at index SAMPLES_PER_EPOCH-1 closes the epoch: next cycle epoch += 1, epoch_errors = epoch count including this sample, running count and index return to 0.
REQ-024 On epoch close, the clean-epoch count SHALL increment if epoch errors = 0, else reset to 0.
REQ-025 Updated clean count = CLEAN_EPOCHS at epoch close -> CONVERGED next cycle, converged=1, done=1 for that cycle.
REQ-026 Otherwise updated epoch = MAX_EPOCHS -> TIMEOUT next cycle, timeout=1, done=1 for that cycle.
REQ-027 Both conditions on the same close SHALL resolve to CONVERGED; converged and timeout never both 1.
REQ-028 Latency: final sample accepted at cycle N -> state, flags, counters and done all updated at N+1; training=0 from N+1.
REQ-029 Gaps (sample_valid=0) in RUN SHALL hold all state; no timeout by cycle count.
REQ-030 done SHALL be 0 in every cycle other than REQ-025/026 transitions.

Reset
REQ-031 rst=1 SHALL force IDLE, training=0, epoch=0, epoch_errors=0, total_errors=0, converged=0, timeout=0, done=0, internal counters 0, next cycle.
REQ-032 rst SHALL override start and sample_valid in the same cycle; rst mid-run discards the partial epoch.

Verification
REQ-033 Defaults; start, then 8 valid samples all matching (pred=+1.0, exp=+1.0) -> after 8th: converged=1, done pulse 1 cycle, epoch=2, total_errors=0, training=0.
REQ-034 Defaults; every epoch has 1 mismatch (pred=+1.0, exp=0) -> after sample 40: timeout=1, epoch=10, epoch_errors=1, total_errors=10.
REQ-035 MAX_EPOCHS=2, CLEAN_EPOCHS=2; 8 matching samples -> converged=1, timeout=0 (priority).
REQ-036 Epochs errors 1,0,1,0,0 -> converged after epoch 5; clean count reset verified; prediction=0 vs expected=0 counts as match.
REQ-037 rst after 3 samples of epoch 1 -> all outputs 0, IDLE; samples without start ignored; start restarts cleanly.
REQ-038 In CONVERGED, sample_valid pulses -> no counter change; start -> counters cleared, training=1 next cycle.
